i2s_tx: RTL
===========

# i2s_tx

I2S master transmitter: accepts stereo sample pairs over a valid/ready handshake, buffers them in a 2-entry FIFO, and serializes them MSB-first onto `o_sd` with standard I2S one-SCK data delay. It generates `o_sck` and `o_ws` from the system clock. It is the playback-side counterpart of the I2S receive path and uses the same 16-SCK-per-channel slot format.

## Interface
- `DATA_WIDTH`, 16: sample width per channel; also the slot length in SCK periods.
- `SCK_DIV`, 4: `o_sck` half-period in `i_sys_clk` cycles, ≥1. SCK = `i_sys_clk`/(2·SCK_DIV).

- `i_sys_clk`  in  1  system clock; all logic on rising edge.
- `i_sys_rst`  in  1  reset; synchronous, active-high.
- `i_enable`  in  1  run request.
- `i_valid`  in  1  sample pair valid.
- `o_ready`  out  1  FIFO not full; transfer when `i_valid & o_ready`.
- `i_left_data`  in  DATA_WIDTH  left sample.
- `i_right_data`  in  DATA_WIDTH  right sample.
- `o_sck`  out  1  serial clock.
- `o_ws`  out  1  word select; 0 = left, 1 = right.
- `o_sd`  out  1  serial data.
- `o_underrun`  out  1  (macro only) one-cycle pulse per zero-filled frame.
- `o_underrun_cnt`  out  8  (macro only) saturating underrun count.

## Operation
- FIFO: 2 entries of {left, right}. `o_ready` = !full. Push and pop in the same cycle are both honoured. There is no bypass: a pop from an empty FIFO is an underrun, even if a push occurs in the same cycle.
- SCK generator: `div_cnt` counts 0..SCK_DIV-1 in RUN/STOPPING. At terminal count, `o_sck` toggles and `div_cnt` resets. A "fall event" is a terminal-count cycle with `o_sck`=1.
- `bit_cnt` runs 0..2·DATA_WIDTH-1 and advances on each fall event, wrapping to 0.
  - `o_ws` = (new `bit_cnt` ≥ DATA_WIDTH), updated on the fall event.
- Shift register: 2·DATA_WIDTH bits, {L,R}. `o_sd` = MSB.
  - Load: on the fall event where `bit_cnt` goes 0→1, pop the FIFO into the register, or load all zeros on underrun.
  - All other fall events shift left by one bit, filling with 0.
  - Result: L MSB appears in slot bit 1 and R LSB appears in `bit_cnt`=0 of the following frame, per I2S one-bit delay.
- FSM states IDLE, RUN, STOPPING:
  - IDLE: `o_sck`, `o_ws`, `o_sd`, `div_cnt`, `bit_cnt` held at 0. Go to RUN when `i_enable` is 1 and the FIFO is non-empty.
  - RUN: free-running. Underrun zero-fills and continues. Go to STOPPING when `i_enable` is 0.
  - STOPPING: continue until the fall event with `bit_cnt` 0→1, then go to IDLE. Do not pop. Force `o_sck`/`o_ws`/`o_sd` to 0 that cycle. The final R LSB has therefore completed.
  - `i_enable` returning to 1 while in STOPPING has no effect until IDLE is reached.
- FIFO contents survive STOPPING→IDLE.

## Timing
- Reset values: `o_sck`=0, `o_ws`=0, `o_sd`=0, `o_ready`=0 while `i_sys_rst`=1. `o_ready`=1 in the first cycle after release. FIFO empty, state IDLE, `o_underrun`=0, `o_underrun_cnt`=0.
- Reset mid-frame aborts at once with no drain; FIFO contents are discarded.
- Start: first `o_sck` rise occurs SCK_DIV cycles after RUN entry. L MSB is on `o_sd` 2·SCK_DIV cycles after RUN entry.
- All outputs are registered. `o_ws`/`o_sd` change only on fall events, SCK_DIV cycles before the next rise.
- Frame period: 2·DATA_WIDTH·2·SCK_DIV cycles (256 at defaults).

## Configuration
- `I2S_TX_UNDERRUN_EN`
  - Defined: `o_underrun` pulses in the load cycle of each zero-filled frame. `o_underrun_cnt` increments and saturates at 255; it is cleared only by reset.
  - Undefined: both ports and their logic are absent. Underrun still zero-fills silently.

## Structure
- Package `i2s_pkg`: FSM state enum (IDLE/RUN/STOPPING) and the frame-width localparam helper (2·DATA_WIDTH).
- Sub-module `i2s_tx_fifo`: 2-entry stereo FIFO with push/pop/full/empty.

## Test plan
- Basic frame (SCK_DIV=2): push L=16'hA5C3, R=16'h0F0F, enable.
  - Required: sampling `o_sd` on `o_sck` rises gives 1 bit of 0, then A5C3 MSB-first with WS=0 for 16 bits, then 0F0F with WS=1.
  - R LSB appears with WS back at 0.
- Backpressure: `i_enable`=0, `i_valid`=1 for 3 cycles.
  - Required: 2 pushes accepted, `o_ready`=0 on the third.
  - After enable and the first pop, `o_ready`=1.
- Underrun: one frame pushed, enable held.
  - Required: the second frame is all-zero SD.
  - `o_underrun` pulses once per frame; `o_underrun_cnt`=1, then 2, and so on.
- Stop: drop `i_enable` at `bit_cnt`=10.
  - Required: the frame completes, R LSB is emitted, and IDLE is reached at the next 0→1 event with outputs 0.
  - The queued frame remains and restarts correctly.
- Reset mid-frame: assert `i_sys_rst` at `bit_cnt`=20.
  - Required: the next cycle shows all outputs 0, `o_ready`=0, and the FIFO empty.
- Simultaneous push and pop with FIFO holding 1 entry.
  - Required: count stays 1 and the pushed data emerges in the next frame.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmitter.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Bits per stereo frame: left slot followed by right slot.
    function automatic int unsigned frame_width(input int unsigned data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Two-entry FIFO of stereo frames; pop reads the head combinationally, no bypass.
module i2s_tx_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             ready,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             do_push;
    logic             do_pop;

    // ready is the registered "not full" flag, held low through reset.
    assign do_push  = push & ready;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            ready  <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count_next;
            ready <= (count_next != 2'd2);
            empty <= (count_next == 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter with 2-entry frame FIFO and one-SCK data delay.
// Optional underrun reporting ports are enabled by defining I2S_TX_UNDERRUN_EN.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SCK_DIV    = 4
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_enable,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_left_data,
    input  logic [DATA_WIDTH-1:0] i_right_data,
    output logic                  o_sck,
    output logic                  o_ws,
    output logic                  o_sd
`ifdef I2S_TX_UNDERRUN_EN
    ,
    output logic                  o_underrun,
    output logic [7:0]            o_underrun_cnt
`endif
);

    localparam int unsigned FW    = frame_width(DATA_WIDTH);
    localparam int unsigned BW    = $clog2(FW);
    localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_next;
    logic              sck;
    logic              ws;
    logic [FW-1:0]     shreg;
    logic [FW-1:0]     fifo_data;
    logic              fifo_empty;
    logic              fifo_ready;
    logic              tc_c;
    logic              fall_c;
    logic              load_c;
    logic              pop_c;

    i2s_tx_fifo #(.WIDTH(FW)) u_fifo (
        .clk       (i_sys_clk),
        .rst       (i_sys_rst),
        .push      (i_valid & fifo_ready),
        .push_data ({i_left_data, i_right_data}),
        .pop       (pop_c),
        .pop_data  (fifo_data),
        .ready     (fifo_ready),
        .empty     (fifo_empty)
    );

    assign o_ready = fifo_ready;
    assign o_sck   = sck;
    assign o_ws    = ws;
    assign o_sd    = shreg[FW-1];

    // Divider terminal count, SCK fall event and frame-load event.
    assign tc_c   = (div_cnt == DIV_W'(SCK_DIV - 1));
    assign fall_c = tc_c & sck;
    assign load_c = fall_c & (bit_cnt == '0);

    always_comb begin
        bit_next = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop_c      = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable && !fifo_empty) state_next = RUN;
            end
            RUN: begin
                pop_c = load_c & ~fifo_empty;
                if (!i_enable) state_next = STOPPING;
            end
            STOPPING: begin
                if (load_c) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial clock, slot counter and shift register; all held at zero in IDLE.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst || state == IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            shreg   <= '0;
        end else begin
            if (tc_c) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_c) begin
                if (state == STOPPING && load_c) begin
                    bit_cnt <= '0;
                    sck     <= 1'b0;
                    ws      <= 1'b0;
                    shreg   <= '0;
                end else begin
                    bit_cnt <= bit_next;
                    ws      <= (bit_next >= BW'(DATA_WIDTH));
                    if (load_c) shreg <= fifo_empty ? '0 : fifo_data;
                    else        shreg <= {shreg[FW-2:0], 1'b0};
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_EN
    logic underrun_c;

    assign underrun_c = (state == RUN) & load_c & fifo_empty;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            o_underrun     <= 1'b0;
            o_underrun_cnt <= 8'd0;
        end else begin
            o_underrun <= underrun_c;
            if (underrun_c && o_underrun_cnt != 8'hFF) o_underrun_cnt <= o_underrun_cnt + 8'd1;
        end
    end
`endif

endmodule
